spi_slave: RTL and testbench

SPI peripheral-side (slave) endpoint that pairs with the team's SPI master block.
- Oversamples the external SCLK/CS/MOSI in the P_clk domain.
- Deserialises MOSI into bytes and serialises a user-supplied byte onto MISO.
- Supports all four SPI modes, MSB first, 8-bit frames, and back-to-back bytes under one CS assertion.
- Sits at the chip boundary, between the pads and a register-file or FIFO client.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 149 ++++++++++++++
 tb/tb_spi_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, CPOL/CPHA extraction, frame width, idle byte.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam logic [7:0]  SPI_IDLE_BYTE = 8'hFF;

  function automatic logic spi_cpol(input int unsigned mode);
    logic [1:0] m;
    m = mode[1:0];
    return m[1];
  endfunction

  function automatic logic spi_cpha(input int unsigned mode);
    logic [1:0] m;
    m = mode[1:0];
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-flop synchroniser plus history flop; o_sync is the synchronised level,
// o_rise/o_fall are single-cycle edge flags.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_hist <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint, oversampled in the P_clk domain, MSB first, 8-bit frames.
// Ports: P_clk/reset_n; pad side i_SCLK, i_CS_n, i_MOSI, o_MISO, o_MISO_EN;
// client side o_RX_DATA/o_RX_DV, i_TX_DATA/i_TX_DV, o_TX_READY, o_TX_UNDERRUN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE     = 0,
  parameter logic [7:0]  TX_IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic       P_clk,
  input  logic       reset_n,
  input  logic       i_SCLK,
  input  logic       i_CS_n,
  input  logic       i_MOSI,
  output logic       o_MISO,
  output logic       o_MISO_EN,
  output logic [7:0] o_RX_DATA,
  output logic       o_RX_DV,
  input  logic [7:0] i_TX_DATA,
  input  logic       i_TX_DV,
  output logic       o_TX_READY,
  output logic       o_TX_UNDERRUN
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise_unused, w_cs_fall;
  logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .i_clk(P_clk), .i_rst_n(reset_n), .i_async(i_SCLK),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(P_clk), .i_rst_n(reset_n), .i_async(i_CS_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise_unused), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(P_clk), .i_rst_n(reset_n), .i_async(i_MOSI),
    .o_sync(w_mosi_sync), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_dv;
  logic [7:0] r_tx_shift;
  logic       r_miso;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_underrun;
  logic       r_first;

  logic       w_cs_act;
  logic       w_lead;
  logic       w_trail;
  logic       w_sample;
  logic       w_shift;
  logic       w_boundary;
  logic       w_load;
  logic [7:0] w_load_byte;

  assign w_cs_act = ~w_cs_sync;
  assign w_lead   = w_cs_act & (CPOL ? w_sclk_fall : w_sclk_rise);
  assign w_trail  = w_cs_act & (CPOL ? w_sclk_rise : w_sclk_fall);
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead : w_trail;

  // A zero count on the shift edge marks a byte boundary; for CPHA=1 the
  // very first leading edge is excluded because CS fall already loaded.
  assign w_boundary = CPHA ? (w_lead & (r_bit_cnt == 3'd0) & ~r_first)
                           : (w_trail & (r_bit_cnt == 3'd0));
  assign w_load      = w_cs_fall | w_boundary;
  assign w_load_byte = r_hold_full ? r_hold : TX_IDLE_BYTE;

  always_ff @(posedge P_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_dv    <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;
      if (!w_cs_act) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi_sync};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data <= {r_rx_shift[6:0], w_mosi_sync};
          r_rx_dv   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge P_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      r_underrun <= 1'b0;

      if (w_cs_fall)   r_first <= 1'b1;
      else if (w_lead) r_first <= 1'b0;

      if (w_load) begin
        r_underrun <= ~r_hold_full;
        // CPHA=1 parks the CS-fall byte; its MSB goes out on the first leading edge.
        if (!CPHA || w_boundary) begin
          r_miso     <= w_load_byte[7];
          r_tx_shift <= {w_load_byte[6:0], 1'b0};
        end else begin
          r_tx_shift <= w_load_byte;
        end
      end else if (w_shift) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end else if (!w_cs_act) begin
        r_miso <= 1'b0;
      end

      // A load consumes the old holding byte; a strobe is accepted only if
      // the holding register was empty before this cycle.
      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (i_TX_DV && !r_hold_full) begin
        r_hold      <= i_TX_DATA;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign o_MISO        = r_miso;
  assign o_MISO_EN     = w_cs_act;
  assign o_RX_DATA     = r_rx_data;
  assign o_RX_DV       = r_rx_dv;
  assign o_TX_READY    = ~r_hold_full;
  assign o_TX_UNDERRUN = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sclk;
  logic [3:0] cs_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic [3:0] tx_dv;
  logic [3:0] miso;
  logic [3:0] miso_en;
  logic [7:0] rx_data [4];
  logic [3:0] rx_dv;
  logic [3:0] tx_ready;
  logic [3:0] underrun;

  logic [1:0] sel = 2'd0;
  logic       cpol;
  logic       cpha;
  int         checks = 0;
  int         failures = 0;
  int         un_cnt = 0;
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .TX_IDLE_BYTE(8'hFF)) u_dut (
      .P_clk(clk), .reset_n(reset_n),
      .i_SCLK(sclk[g]), .i_CS_n(cs_n[g]), .i_MOSI(mosi),
      .o_MISO(miso[g]), .o_MISO_EN(miso_en[g]),
      .o_RX_DATA(rx_data[g]), .o_RX_DV(rx_dv[g]),
      .i_TX_DATA(tx_data), .i_TX_DV(tx_dv[g]),
      .o_TX_READY(tx_ready[g]), .o_TX_UNDERRUN(underrun[g])
    );
  end

  always @(negedge clk) begin
    if (rx_dv[sel]) rx_q.push_back(rx_data[sel]);
    if (underrun[sel]) un_cnt <= un_cnt + 1;
  end

  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      sclk[i] = (i >= 2);
      cs_n[i] = 1'b1;
      tx_dv[i] = 1'b0;
    end
    mosi = 1'b0;
    tx_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_dv[sel] = 1'b1;
    @(negedge clk);
    tx_dv[sel] = 1'b0;
  endtask

  // Master side of one frame (or nbits of it), SCLK half period = 4 P_clk.
  task automatic m_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        half_bit();
        rx[7-i] = miso[sel];
        sclk[sel] = ~cpol;
        half_bit();
        sclk[sel] = cpol;
      end else begin
        half_bit();
        sclk[sel] = ~cpol;
        mosi = tx[7-i];
        half_bit();
        rx[7-i] = miso[sel];
        sclk[sel] = cpol;
      end
    end
  endtask

  task automatic test_reset();
    sel = 2'd0;
    do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (miso[0] !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", miso[0]); end
    if (miso_en[0] !== 1'b0) begin failures++; $display("FAIL reset_miso_en got=%b exp=0", miso_en[0]); end
    if (rx_data[0] !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data[0]); end
    if (rx_dv[0] !== 1'b0) begin failures++; $display("FAIL reset_rx_dv got=%b exp=0", rx_dv[0]); end
    if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready[0]); end
    if (underrun[0] !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun[0]); end
    reset_n = 1'b1;
  endtask

  task automatic test_mode(input logic [1:0] m, input logic [7:0] mo, input logic [7:0] tx);
    logic [7:0] mrx;
    logic [7:0] got;
    int q0, u0;
    sel = m; cpol = m[1]; cpha = m[0];
    do_reset();
    q0 = rx_q.size(); u0 = un_cnt;
    load_tx(tx);
    checks++;
    if (tx_ready[sel] !== 1'b0) begin failures++; $display("FAIL mode%0d_ready_loaded got=%b exp=0", m, tx_ready[sel]); end
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (tx_ready[sel] !== 1'b1) begin failures++; $display("FAIL mode%0d_ready_cs_fall got=%b exp=1", m, tx_ready[sel]); end
    if (miso_en[sel] !== 1'b1) begin failures++; $display("FAIL mode%0d_miso_en_active got=%b exp=1", m, miso_en[sel]); end
    if (!cpha) load_tx(8'h00);
    m_byte(mo, 8, mrx);
    half_bit();
    cs_n[sel] = 1'b1;
    repeat (4) @(negedge clk);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    checks += 5;
    if (rx_q.size() - q0 != 1) begin failures++; $display("FAIL mode%0d_rx_dv_count got=%0d exp=1", m, rx_q.size() - q0); end
    if (got !== mo) begin failures++; $display("FAIL mode%0d_rx_data got=%h exp=%h", m, got, mo); end
    if (mrx !== tx) begin failures++; $display("FAIL mode%0d_master_rx got=%h exp=%h", m, mrx, tx); end
    if (un_cnt != u0) begin failures++; $display("FAIL mode%0d_underrun got=%0d exp=0", m, un_cnt - u0); end
    if (miso_en[sel] !== 1'b0) begin failures++; $display("FAIL mode%0d_miso_en_idle got=%b exp=0", m, miso_en[sel]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mo [3];
    logic [7:0] tx [3];
    logic [7:0] mrx;
    logic [7:0] got;
    int q0;
    mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03;
    tx[0] = 8'hA1; tx[1] = 8'hB2; tx[2] = 8'hC3;
    sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
    do_reset();
    q0 = rx_q.size();
    load_tx(tx[0]);
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      if (b > 0) repeat (4) @(negedge clk);
      if (b < 2) load_tx(tx[b+1]);
      m_byte(mo[b], 8, mrx);
      checks++;
      if (mrx !== tx[b]) begin failures++; $display("FAIL b2b_master_rx%0d got=%h exp=%h", b, mrx, tx[b]); end
    end
    half_bit();
    cs_n[sel] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() - q0 != 3) begin failures++; $display("FAIL b2b_rx_dv_count got=%0d exp=3", rx_q.size() - q0); end
    for (int b = 0; b < 3; b++) begin
      got = (rx_q.size() > q0 + b) ? rx_q[q0+b] : 8'hxx;
      checks++;
      if (got !== mo[b]) begin failures++; $display("FAIL b2b_rx_data%0d got=%h exp=%h", b, got, mo[b]); end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mrx;
    logic [7:0] got;
    int q0, u0;
    sel = 2'd1; cpol = 1'b0; cpha = 1'b1;
    do_reset();
    q0 = rx_q.size(); u0 = un_cnt;
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    m_byte(8'h55, 8, mrx);
    half_bit();
    cs_n[sel] = 1'b1;
    repeat (4) @(negedge clk);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    checks += 3;
    if (mrx !== 8'hFF) begin failures++; $display("FAIL underrun_master_rx got=%h exp=ff", mrx); end
    if (got !== 8'h55) begin failures++; $display("FAIL underrun_rx_data got=%h exp=55", got); end
    if (un_cnt - u0 != 1) begin failures++; $display("FAIL underrun_pulses got=%0d exp=1", un_cnt - u0); end
  endtask

  task automatic test_abort();
    logic [7:0] mrx;
    logic [7:0] got;
    int q0;
    sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
    do_reset();
    q0 = rx_q.size();
    load_tx(8'h5A);
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    m_byte(8'hF0, 5, mrx);
    half_bit();
    cs_n[sel] = 1'b1;
    repeat (4) @(negedge clk);
    checks += 2;
    if (rx_q.size() != q0) begin failures++; $display("FAIL abort_rx_dv got=%0d exp=0", rx_q.size() - q0); end
    if (miso_en[sel] !== 1'b0) begin failures++; $display("FAIL abort_miso_en got=%b exp=0", miso_en[sel]); end
    load_tx(8'h96);
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    load_tx(8'h00);
    m_byte(8'hC3, 8, mrx);
    half_bit();
    cs_n[sel] = 1'b1;
    repeat (4) @(negedge clk);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    checks += 3;
    if (rx_q.size() - q0 != 1) begin failures++; $display("FAIL abort_next_dv_count got=%0d exp=1", rx_q.size() - q0); end
    if (got !== 8'hC3) begin failures++; $display("FAIL abort_next_rx_data got=%h exp=c3", got); end
    if (mrx !== 8'h96) begin failures++; $display("FAIL abort_next_master_rx got=%h exp=96", mrx); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mrx;
    logic [7:0] got;
    int q0;
    sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
    do_reset();
    q0 = rx_q.size();
    load_tx(8'h5A);
    load_tx(8'hE7);
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    m_byte(8'h99, 8, mrx);
    half_bit();
    cs_n[sel] = 1'b1;
    repeat (4) @(negedge clk);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    checks += 2;
    if (mrx !== 8'h5A) begin failures++; $display("FAIL ignored_dv_master_rx got=%h exp=5a", mrx); end
    if (got !== 8'h99) begin failures++; $display("FAIL ignored_dv_rx_data got=%h exp=99", got); end
    cs_n[sel] = 1'b0;
    repeat (3) @(negedge clk);
    load_tx(8'h42);
    m_byte(8'h12, 4, mrx);
    sclk[sel] = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (miso[sel] !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b exp=0", miso[sel]); end
    if (miso_en[sel] !== 1'b0) begin failures++; $display("FAIL midrst_miso_en got=%b exp=0", miso_en[sel]); end
    if (rx_data[sel] !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data[sel]); end
    if (rx_dv[sel] !== 1'b0) begin failures++; $display("FAIL midrst_rx_dv got=%b exp=0", rx_dv[sel]); end
    if (tx_ready[sel] !== 1'b1) begin failures++; $display("FAIL midrst_tx_ready got=%b exp=1", tx_ready[sel]); end
    if (underrun[sel] !== 1'b0) begin failures++; $display("FAIL midrst_underrun got=%b exp=0", underrun[sel]); end
    sclk[sel] = 1'b0;
    cs_n[sel] = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mode(2'd0, 8'h3C, 8'hA5);
    test_mode(2'd1, 8'h81, 8'h7E);
    test_mode(2'd2, 8'h81, 8'h7E);
    test_mode(2'd3, 8'h81, 8'h7E);
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
